id_ex_stage: RTL

//  ID/EX pipeline register plus the execute-side operand logic that drives the ALU.

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/forwarding_unit.sv | 40 ++++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX stage: ALU operation codes, forwarding selects
// and the control bundle carried down the pipe.
package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_BLT = 4'b1001,
        ALU_BGE = 4'b1010,
        ALU_BNE = 4'b1011,
        ALU_SLT = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ex_ctrl_t;

    // Control of an empty slot: nothing written, nothing accessed.
    localparam ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding selection for both ALU source registers.
// EX/MEM has priority over MEM/WB; register x0 is never forwarded.
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_ex_rs1,
    input  logic [REG_ADDR_W-1:0] i_ex_rs2,
    input  logic [REG_ADDR_W-1:0] i_exm_rd,
    input  logic                  i_exm_regwrite,
    input  logic [REG_ADDR_W-1:0] i_mwb_rd,
    input  logic                  i_mwb_regwrite,
    output fwd_sel_t              o_fwd_a,
    output fwd_sel_t              o_fwd_b
);

    function automatic fwd_sel_t pick_source(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] exm_rd,
        input logic                  exm_we,
        input logic [REG_ADDR_W-1:0] mwb_rd,
        input logic                  mwb_we
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (exm_we && (exm_rd != '0) && (exm_rd == rs))
            sel = FWD_EXM;
        else if (mwb_we && (mwb_rd != '0) && (mwb_rd == rs))
            sel = FWD_MWB;
        return sel;
    endfunction

    // Resolve the data source for each operand independently
    always_comb begin
        o_fwd_a = pick_source(i_ex_rs1, i_exm_rd, i_exm_regwrite, i_mwb_rd, i_mwb_regwrite);
        o_fwd_b = pick_source(i_ex_rs2, i_exm_rd, i_exm_regwrite, i_mwb_rd, i_mwb_regwrite);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand forwarding and
// load-use hazard detection. Bubbles are inserted on flush or load-use.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic [4:0]               id_ctrl,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exm_rd,
    input  logic                     exm_regwrite,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic [REG_ADDR_W-1:0]    mwb_rd,
    input  logic                     mwb_regwrite,
    input  logic [DATA_WIDTH-1:0]    mwb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic [4:0]               ex_ctrl,
    output logic                     load_use_hazard
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_pc;
    logic [DATA_WIDTH-1:0]    r_rs1_data;
    logic [DATA_WIDTH-1:0]    r_rs2_data;
    logic [DATA_WIDTH-1:0]    r_imm;
    logic [REG_ADDR_W-1:0]    r_rs1;
    logic [REG_ADDR_W-1:0]    r_rs2;
    logic [REG_ADDR_W-1:0]    r_rd;
    logic [OPCODE_LENGTH-1:0] r_alu_op;
    logic                     r_alu_src;
    ex_ctrl_t                 r_ctrl;

    logic                     w_load_use;
    fwd_sel_t                 w_fwd_a;
    fwd_sel_t                 w_fwd_b;
    logic [DATA_WIDTH-1:0]    w_fwd_rs1;
    logic [DATA_WIDTH-1:0]    w_fwd_rs2;

    // A load in EX whose destination feeds the instruction in ID must wait a cycle
    assign w_load_use = r_valid & r_ctrl.memread & (r_rd != '0) &
                        ((r_rd == id_rs1) | (r_rd == id_rs2));

    // Pipeline register: flush beats stall, stall beats the load-use bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alu_op   <= '0;
            r_alu_src  <= 1'b0;
            r_ctrl     <= BUBBLE;
        end else if (flush || (!stall && w_load_use)) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alu_op   <= '0;
            r_alu_src  <= 1'b0;
            r_ctrl     <= BUBBLE;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alu_op   <= id_alu_op;
            r_alu_src  <= id_alu_src;
            r_ctrl     <= ex_ctrl_t'(id_ctrl);
        end
    end

    forwarding_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd (
        .i_ex_rs1      (r_rs1),
        .i_ex_rs2      (r_rs2),
        .i_exm_rd      (exm_rd),
        .i_exm_regwrite(exm_regwrite),
        .i_mwb_rd      (mwb_rd),
        .i_mwb_regwrite(mwb_regwrite),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    // Operand muxes: forwarded values, then immediate select for SrcB
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        case (w_fwd_a)
            FWD_EXM: w_fwd_rs1 = exm_result;
            FWD_MWB: w_fwd_rs1 = mwb_result;
            default: w_fwd_rs1 = r_rs1_data;
        endcase
        case (w_fwd_b)
            FWD_EXM: w_fwd_rs2 = exm_result;
            FWD_MWB: w_fwd_rs2 = mwb_result;
            default: w_fwd_rs2 = r_rs2_data;
        endcase
    end

    assign SrcA            = w_fwd_rs1;
    assign SrcB            = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data   = w_fwd_rs2;
    assign Operation       = r_alu_op;
    assign ex_valid        = r_valid;
    assign ex_pc           = r_pc;
    assign ex_imm          = r_imm;
    assign ex_rd           = r_rd;
    assign ex_ctrl         = r_ctrl;
    assign load_use_hazard = w_load_use;

endmodule
